// File: rtl/gate_recv.sv
// gate_recv: receive-side route-capability gate.
// A host-programmed table holds one capability byte per UL destination. A packet
// is forwarded through a single output register stage only if its header route
// byte equals the valid table entry for its destination; otherwise every beat of
// the packet is consumed and discarded. Pass and drop counts saturate at 16'hFFFF.
module gate_recv #(
  parameter int unsigned N_DESTS = 4,
  parameter int unsigned DATA_W  = 64
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [7:0]        host_route_cap_in,
  input  logic              host_route_cap_valid,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [1:0]        ul_port_out,
  output logic [15:0]       pass_cnt_out,
  output logic [15:0]       drop_cnt_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_DROP
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          cap_q [N_DESTS];
  logic [7:0]          cap_d [N_DESTS];
  logic [N_DESTS-1:0]  cap_vld_q, cap_vld_d;
  logic                m_tvalid_q, m_tvalid_d;
  logic [DATA_W-1:0]   m_tdata_q, m_tdata_d;
  logic                m_tlast_q, m_tlast_d;
  logic [1:0]          ul_port_q, ul_port_d;
  logic [15:0]         pass_cnt_q, pass_cnt_d;
  logic [15:0]         drop_cnt_q, drop_cnt_d;

  logic [7:0]          rb;
  logic                hit;
  logic                accept;
  logic                load;

  assign rb = s_tdata[7:0];

  // Route match: entries beyond N_DESTS never match since no loop index reaches them
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < N_DESTS; i++) begin
      if ((rb[1:0] == 2'(i)) && cap_vld_q[i] && (cap_q[i] == rb)) begin
        hit = 1'b1;
      end
    end
  end

  // Table write: takes effect next cycle, so a same-cycle header sees the old entry
  always_comb begin
    cap_d     = cap_q;
    cap_vld_d = cap_vld_q;
    if (host_route_cap_valid) begin
      for (int unsigned i = 0; i < N_DESTS; i++) begin
        if (host_route_cap_in[1:0] == 2'(i)) begin
          cap_d[i]     = host_route_cap_in;
          cap_vld_d[i] = 1'b1;
        end
      end
    end
  end

  // Ready: drop beats are consumed freely, others need a free output register
  always_comb begin
    s_tready = (state_q == ST_DROP) || !m_tvalid_q || m_tready;
  end

  // Packet FSM, output register load and saturating counters
  always_comb begin
    accept     = s_tvalid && s_tready;
    load       = 1'b0;
    state_d    = state_q;
    m_tvalid_d = m_tvalid_q && !m_tready;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    ul_port_d  = ul_port_q;
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (hit) begin
            load      = 1'b1;
            ul_port_d = rb[1:0];
            if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 16'd1;
            state_d   = s_tlast ? ST_IDLE : ST_PASS;
          end else begin
            if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 16'd1;
            state_d   = s_tlast ? ST_IDLE : ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (accept) begin
          load = 1'b1;
          if (s_tlast) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (accept && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = s_tdata;
      m_tlast_d  = s_tlast;
    end
  end

  // State, table and output registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      cap_vld_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
      ul_port_q  <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int unsigned i = 0; i < N_DESTS; i++) cap_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cap_vld_q  <= cap_vld_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
      ul_port_q  <= ul_port_d;
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      for (int unsigned i = 0; i < N_DESTS; i++) cap_q[i] <= cap_d[i];
    end
  end

  assign m_tvalid     = m_tvalid_q;
  assign m_tdata      = m_tdata_q;
  assign m_tlast      = m_tlast_q;
  assign ul_port_out  = ul_port_q;
  assign pass_cnt_out = pass_cnt_q;
  assign drop_cnt_out = drop_cnt_q;

endmodule

// File: tb/tb_gate_recv.sv
// Directed bench for gate_recv: program, pass, drop, backpressure, same-cycle
// table update, back-to-back single-beat packets and mid-packet reset.
module tb_gate_recv;

  logic        aclk;
  logic        areset;
  logic [7:0]  host_route_cap_in;
  logic        host_route_cap_valid;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic [1:0]  ul_port_out;
  logic [15:0] pass_cnt_out;
  logic [15:0] drop_cnt_out;

  int n_cmp;
  int n_err;

  gate_recv #(.N_DESTS(4), .DATA_W(64)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .host_route_cap_in    (host_route_cap_in),
    .host_route_cap_valid (host_route_cap_valid),
    .s_tvalid             (s_tvalid),
    .s_tready             (s_tready),
    .s_tdata              (s_tdata),
    .s_tlast              (s_tlast),
    .m_tvalid             (m_tvalid),
    .m_tready             (m_tready),
    .m_tdata              (m_tdata),
    .m_tlast              (m_tlast),
    .ul_port_out          (ul_port_out),
    .pass_cnt_out         (pass_cnt_out),
    .drop_cnt_out         (drop_cnt_out)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    areset = 1'b1;
    host_route_cap_in = 8'h00;
    host_route_cap_valid = 1'b0;
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    m_tready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_ul", ul_port_out, 0);
    chk("rst_pass", pass_cnt_out, 0);
    chk("rst_drop", drop_cnt_out, 0);
    areset = 1'b0;

    // 1: program A5 for id 1, forward a 3-beat packet
    tick();
    host_route_cap_in = 8'hA5; host_route_cap_valid = 1'b1;
    tick();
    host_route_cap_valid = 1'b0;
    drive(1, 64'h1111_0000_0000_00A5, 0);
    #1;
    chk("t1_s_tready", s_tready, 1);
    chk("t1_no_comb_path", m_tvalid, 0);
    tick();
    drive(1, 64'h2222_0000_0000_0000, 0);
    #1;
    chk("t1_b0_valid", m_tvalid, 1);
    chk("t1_b0_data", m_tdata, 64'h1111_0000_0000_00A5);
    chk("t1_ul", ul_port_out, 1);
    chk("t1_pass", pass_cnt_out, 1);
    tick();
    drive(1, 64'h3333_0000_0000_0001, 1);
    #1;
    chk("t1_b1_data", m_tdata, 64'h2222_0000_0000_0000);
    chk("t1_b1_last", m_tlast, 0);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t1_b2_data", m_tdata, 64'h3333_0000_0000_0001);
    chk("t1_b2_last", m_tlast, 1);
    tick();
    #1;
    chk("t1_drained", m_tvalid, 0);

    // 2: mismatch on id 1, then unprogrammed id 2
    drive(1, 64'h1111_0000_0000_00A1, 0);
    tick();
    drive(1, 64'h2222_0000_0000_0000, 0);
    m_tready = 1'b0;
    #1;
    chk("t2_drop_ready", s_tready, 1);
    chk("t2_no_valid", m_tvalid, 0);
    chk("t2_drop1", drop_cnt_out, 1);
    tick();
    drive(1, 64'h3333_0000_0000_0000, 1);
    #1;
    chk("t2_drop_ready_b2", s_tready, 1);
    tick();
    drive(1, 64'h4444_0000_0000_0002, 1);
    m_tready = 1'b1;
    #1;
    chk("t2_id2_no_valid", m_tvalid, 0);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t2_drop2", drop_cnt_out, 2);
    chk("t2_pass_kept", pass_cnt_out, 1);
    chk("t2_still_no_valid", m_tvalid, 0);

    // 3: backpressure during a passed packet, dropped packet queued behind it
    m_tready = 1'b0;
    drive(1, 64'h3333_0000_0000_00A5, 0);
    tick();
    drive(1, 64'h3333_1111_0000_0000, 0);
    #1;
    chk("t3_hdr_valid", m_tvalid, 1);
    chk("t3_stall_ready", s_tready, 0);
    chk("t3_pass2", pass_cnt_out, 2);
    tick();
    #1;
    chk("t3_hold_data", m_tdata, 64'h3333_0000_0000_00A5);
    chk("t3_hold_ready", s_tready, 0);
    m_tready = 1'b1;
    #1;
    chk("t3_release_ready", s_tready, 1);
    tick();
    drive(1, 64'h3333_2222_0000_0001, 1);
    m_tready = 1'b0;
    #1;
    chk("t3_b1_data", m_tdata, 64'h3333_1111_0000_0000);
    tick();
    #1;
    chk("t3_b1_held", m_tdata, 64'h3333_1111_0000_0000);
    m_tready = 1'b1;
    tick();
    drive(1, 64'h5555_0000_0000_00A2, 1);
    m_tready = 1'b0;
    #1;
    chk("t3_b2_data", m_tdata, 64'h3333_2222_0000_0001);
    chk("t3_b2_last", m_tlast, 1);
    chk("t3_drop_blocked", s_tready, 0);
    tick();
    #1;
    chk("t3_drop_not_taken", drop_cnt_out, 2);
    chk("t3_b2_held", m_tdata, 64'h3333_2222_0000_0001);
    m_tready = 1'b1;
    #1;
    chk("t3_drain_ready", s_tready, 1);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t3_drop3", drop_cnt_out, 3);
    chk("t3_out_empty", m_tvalid, 0);
    chk("t3_pass2_kept", pass_cnt_out, 2);

    // 4: header checked against the old entry during a same-cycle write
    host_route_cap_in = 8'hB5; host_route_cap_valid = 1'b1;
    drive(1, 64'h4444_0000_0000_00A5, 1);
    tick();
    host_route_cap_valid = 1'b0;
    drive(1, 64'h5555_0000_0000_00B5, 1);
    #1;
    chk("t4_old_passed", m_tdata, 64'h4444_0000_0000_00A5);
    chk("t4_pass3", pass_cnt_out, 3);
    tick();
    drive(1, 64'h6666_0000_0000_00A5, 1);
    #1;
    chk("t4_new_passed", m_tdata, 64'h5555_0000_0000_00B5);
    chk("t4_pass4", pass_cnt_out, 4);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t4_old_dropped", drop_cnt_out, 4);
    chk("t4_no_valid", m_tvalid, 0);
    chk("t4_pass4_kept", pass_cnt_out, 4);

    // 5: back-to-back single-beat pass, drop, pass
    drive(1, 64'h7777_0000_0000_00B5, 1);
    tick();
    drive(1, 64'h8888_0000_0000_00A5, 1);
    #1;
    chk("t5_p1_valid", m_tvalid, 1);
    chk("t5_p1_data", m_tdata, 64'h7777_0000_0000_00B5);
    chk("t5_p1_ready", s_tready, 1);
    tick();
    drive(1, 64'h9999_0000_0000_00B5, 1);
    #1;
    chk("t5_drop_gap", m_tvalid, 0);
    chk("t5_drop5", drop_cnt_out, 5);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t5_p2_data", m_tdata, 64'h9999_0000_0000_00B5);
    chk("t5_p2_last", m_tlast, 1);
    chk("t5_pass6", pass_cnt_out, 6);
    tick();
    #1;
    chk("t5_drained", m_tvalid, 0);

    // 6: reset in the middle of a passed packet
    drive(1, 64'hAAAA_0000_0000_00B5, 0);
    tick();
    drive(1, 64'hBBBB_0000_0000_0000, 0);
    tick();
    #1;
    chk("t6_pre_data", m_tdata, 64'hBBBB_0000_0000_0000);
    chk("t6_pre_pass", pass_cnt_out, 7);
    areset = 1'b1;
    #1;
    chk("t6_rst_valid", m_tvalid, 0);
    chk("t6_rst_data", m_tdata, 0);
    chk("t6_rst_pass", pass_cnt_out, 0);
    chk("t6_rst_drop", drop_cnt_out, 0);
    tick();
    areset = 1'b0;
    drive(1, 64'hCCCC_0000_0000_00B5, 1);
    tick();
    drive(0, '0, 0);
    #1;
    chk("t6_hdr_dropped", drop_cnt_out, 1);
    chk("t6_no_pass", pass_cnt_out, 0);
    chk("t6_no_valid", m_tvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
